// File: rtl/mdio_arbiter_pkg.sv
// rtl/mdio_arbiter_pkg.sv - shared FSM state encoding and Clause 22 opcodes for the MDIO arbiter
package mdio_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } mdio_state_t;

    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_WRITE = 2'b01;

    // Map the requester direction bit onto the Clause 22 opcode
    function automatic logic [1:0] op_of(input logic rw);
        return rw ? OP_READ : OP_WRITE;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin winner selection with last-served pointer
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       update,
    input  logic       served,
    output logic       valid,
    output logic       winner
);

    logic last;

    assign valid = |req;

    // On a tie the requester not served last wins; a lone requester always wins
    always_comb begin
        winner = 1'b0;
        if (req == 2'b11) begin
            winner = ~last;
        end else if (req[1]) begin
            winner = 1'b1;
        end
    end

    // Last-served pointer; starts at r1 so r0 takes the first tie
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last <= 1'b1;
        end else if (update) begin
            last <= served;
        end
    end

endmodule

// File: rtl/mdio_arbiter.sv
// rtl/mdio_arbiter.sv - two-requester arbiter in front of a single MDIO engine
module mdio_arbiter
    import mdio_arbiter_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 256,
    parameter logic [15:0] IDLE_RDATA     = 16'hFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        r0_req,
    input  logic        r0_rw,
    input  logic [4:0]  r0_phy,
    input  logic [4:0]  r0_reg,
    input  logic [15:0] r0_wdata,
    output logic        r0_gnt,
    output logic        r0_done,
    output logic        r0_err,
    output logic [15:0] r0_rdata,
    input  logic        r1_req,
    input  logic        r1_rw,
    input  logic [4:0]  r1_phy,
    input  logic [4:0]  r1_reg,
    input  logic [15:0] r1_wdata,
    output logic        r1_gnt,
    output logic        r1_done,
    output logic        r1_err,
    output logic [15:0] r1_rdata,
    output logic        m_start,
    output logic        m_rw,
    output logic [4:0]  m_phy,
    output logic [4:0]  m_reg,
    output logic [15:0] m_wdata,
    input  logic [15:0] m_rdata,
    input  logic        m_done
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    mdio_state_t      state;
    logic             owner;
    logic [1:0]       op_q;
    logic [CNT_W-1:0] cnt;

    logic             arb_valid;
    logic             arb_winner;
    logic             arb_update;

    logic             sel_rw;
    logic [4:0]       sel_phy;
    logic [4:0]       sel_reg;
    logic [15:0]      sel_wdata;

    logic             timeout_hit;
    logic             finish;
    logic             fin_err;
    logic [15:0]      fin_rdata;

    assign arb_update = (state == ST_DONE);

    rr_arb2 u_arb (
        .clk    (clk),
        .reset  (reset),
        .req    ({r1_req, r0_req}),
        .update (arb_update),
        .served (owner),
        .valid  (arb_valid),
        .winner (arb_winner)
    );

    // Direction is kept as the bus opcode; m_rw is derived from it
    assign m_rw = (op_q == OP_READ);

    // An engine completion beats a timeout landing on the same edge
    assign timeout_hit = (cnt == CNT_LAST);
    assign finish      = m_done | timeout_hit;
    assign fin_err     = ~m_done;
    assign fin_rdata   = m_done ? m_rdata : IDLE_RDATA;

    // Route the winning requester's command fields toward the engine latches
    always_comb begin
        sel_rw    = r0_rw;
        sel_phy   = r0_phy;
        sel_reg   = r0_reg;
        sel_wdata = r0_wdata;
        if (arb_winner) begin
            sel_rw    = r1_rw;
            sel_phy   = r1_phy;
            sel_reg   = r1_reg;
            sel_wdata = r1_wdata;
        end
    end

    // Transaction FSM: grant, start pulse, wait with timeout, completion pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            owner    <= 1'b0;
            op_q     <= 2'b00;
            cnt      <= '0;
            m_start  <= 1'b0;
            m_phy    <= '0;
            m_reg    <= '0;
            m_wdata  <= '0;
            r0_gnt   <= 1'b0;
            r0_done  <= 1'b0;
            r0_err   <= 1'b0;
            r0_rdata <= '0;
            r1_gnt   <= 1'b0;
            r1_done  <= 1'b0;
            r1_err   <= 1'b0;
            r1_rdata <= '0;
        end else begin
            m_start <= 1'b0;
            r0_done <= 1'b0;
            r1_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (arb_valid) begin
                        owner   <= arb_winner;
                        op_q    <= op_of(sel_rw);
                        m_phy   <= sel_phy;
                        m_reg   <= sel_reg;
                        m_wdata <= sel_wdata;
                        m_start <= 1'b1;
                        r0_gnt  <= ~arb_winner;
                        r1_gnt  <= arb_winner;
                        state   <= ST_START;
                    end
                end
                ST_START: begin
                    cnt   <= '0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (finish) begin
                        state <= ST_DONE;
                        if (owner) begin
                            r1_done <= 1'b1;
                            r1_err  <= fin_err;
                            if (m_rw) begin
                                r1_rdata <= fin_rdata;
                            end
                        end else begin
                            r0_done <= 1'b1;
                            r0_err  <= fin_err;
                            if (m_rw) begin
                                r0_rdata <= fin_rdata;
                            end
                        end
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    r0_gnt <= 1'b0;
                    r1_gnt <= 1'b0;
                    r0_err <= 1'b0;
                    r1_err <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdio_arbiter.sv
// tb/tb_mdio_arbiter.sv - scoreboard bench for mdio_arbiter
module tb_mdio_arbiter;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        r0_req, r0_rw, r0_gnt, r0_done, r0_err;
    logic [4:0]  r0_phy, r0_reg;
    logic [15:0] r0_wdata, r0_rdata;
    logic        r1_req, r1_rw, r1_gnt, r1_done, r1_err;
    logic [4:0]  r1_phy, r1_reg;
    logic [15:0] r1_wdata, r1_rdata;
    logic        m_start, m_rw, m_done;
    logic [4:0]  m_phy, m_reg;
    logic [15:0] m_wdata, m_rdata;

    typedef struct packed {
        logic        id;
        logic        rw;
        logic [4:0]  phy;
        logic [4:0]  rg;
        logic [15:0] wd;
    } cmd_t;

    typedef struct packed {
        logic        id;
        logic        err;
        logic [15:0] rd;
        logic [7:0]  lat;
    } rsp_t;

    cmd_t        exp_cmd_q[$];
    rsp_t        exp_rsp_q[$];
    logic [15:0] mdl_rd[2];
    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          start_cyc = 0;
    logic        active = 1'b0;
    cmd_t        cur;
    rsp_t        r_mon;

    mdio_arbiter #(.TIMEOUT_CYCLES(TO), .IDLE_RDATA(16'hFFFF)) dut (
        .clk(clk), .reset(reset),
        .r0_req(r0_req), .r0_rw(r0_rw), .r0_phy(r0_phy), .r0_reg(r0_reg), .r0_wdata(r0_wdata),
        .r0_gnt(r0_gnt), .r0_done(r0_done), .r0_err(r0_err), .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_rw(r1_rw), .r1_phy(r1_phy), .r1_reg(r1_reg), .r1_wdata(r1_wdata),
        .r1_gnt(r1_gnt), .r1_done(r1_done), .r1_err(r1_err), .r1_rdata(r1_rdata),
        .m_start(m_start), .m_rw(m_rw), .m_phy(m_phy), .m_reg(m_reg), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_done(m_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Monitor: compare engine commands and completions against the scoreboard
    always @(negedge clk) begin
        if (reset) begin
            active = 1'b0;
        end else begin
            if (r0_gnt || r1_gnt) check("gnt_excl", r0_gnt & r1_gnt, 0);
            if (m_start) begin
                if (exp_cmd_q.size() == 0) begin
                    check("cmd_unexpected", 1, 0);
                end else begin
                    cur = exp_cmd_q.pop_front();
                    check("cmd", {r1_gnt, r0_gnt, m_rw, m_phy, m_reg, m_wdata},
                          {cur.id, ~cur.id, cur.rw, cur.phy, cur.rg, cur.wd});
                    start_cyc = cyc;
                    active = 1'b1;
                end
            end else if (active) begin
                check("m_stable", {m_rw, m_phy, m_reg, m_wdata}, {cur.rw, cur.phy, cur.rg, cur.wd});
            end
            if (r0_done || r1_done) begin
                check("other_idle", r1_done ? {r0_gnt, r0_done} : {r1_gnt, r1_done}, 0);
                if (exp_rsp_q.size() == 0) begin
                    check("rsp_unexpected", 1, 0);
                end else begin
                    r_mon = exp_rsp_q.pop_front();
                    check("rsp_id", r1_done, r_mon.id);
                    check("rsp_err", r1_done ? r1_err : r0_err, r_mon.err);
                    check("rsp_rdata", r1_done ? r1_rdata : r0_rdata, r_mon.rd);
                    check("rsp_lat", 64'(cyc - start_cyc), r_mon.lat);
                end
                active = 1'b0;
            end
        end
    end

    task automatic set_req(input int id, input logic v, input logic rw, input logic [4:0] phy,
                           input logic [4:0] rg, input logic [15:0] wd);
        if (id == 0) begin
            r0_req = v; r0_rw = rw; r0_phy = phy; r0_reg = rg; r0_wdata = wd;
        end else begin
            r1_req = v; r1_rw = rw; r1_phy = phy; r1_reg = rg; r1_wdata = wd;
        end
    endtask

    task automatic wait_start(input int bound);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (m_start) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check("start_timeout", 0, 1);
    endtask

    task automatic wait_done(input int id, input int bound);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if ((id == 0 && r0_done) || (id == 1 && r1_done)) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check("done_timeout", 0, 1);
        @(posedge clk);
        #1;
        if (id == 0) r0_req = 1'b0; else r1_req = 1'b0;
    endtask

    // One transaction; the engine pulses m_done 'delay' cycles after m_start (never if negative)
    task automatic run_txn(input int id, input logic rw, input logic [4:0] phy, input logic [4:0] rg,
                           input logic [15:0] wd, input int delay, input logic [15:0] eng_rd);
        logic ok;
        cmd_t c;
        rsp_t r;
        ok = (delay >= 1) && (delay <= TO);
        if (rw) mdl_rd[id] = ok ? eng_rd : 16'hFFFF;
        c.id = id[0]; c.rw = rw; c.phy = phy; c.rg = rg; c.wd = wd;
        r.id = id[0]; r.err = ~ok; r.rd = mdl_rd[id];
        r.lat = ok ? 8'(delay + 1) : 8'(TO + 1);
        exp_cmd_q.push_back(c);
        exp_rsp_q.push_back(r);
        @(posedge clk);
        #1;
        set_req(id, 1'b1, rw, phy, rg, wd);
        wait_start(10);
        fork
            begin
                if (delay >= 0) begin
                    repeat (delay) @(posedge clk);
                    #1;
                    m_done = 1'b1;
                    m_rdata = eng_rd;
                    @(posedge clk);
                    #1;
                    m_done = 1'b0;
                    m_rdata = 16'h0;
                end
            end
            wait_done(id, 40);
        join
    endtask

    // Both requesters held high: grants must alternate starting from r0
    task automatic run_tie(input int n);
        cmd_t c;
        rsp_t r;
        for (int k = 0; k < n; k++) begin
            c.id = k[0];
            c.rw = k[0];
            c.phy = k[0] ? 5'd4 : 5'd3;
            c.rg = k[0] ? 5'd8 : 5'd7;
            c.wd = k[0] ? 16'h2222 : 16'h1111;
            exp_cmd_q.push_back(c);
            if (k[0]) mdl_rd[1] = 16'hC000 + 16'(k);
            r.id = k[0]; r.err = 1'b0; r.rd = mdl_rd[k % 2]; r.lat = 8'd3;
            exp_rsp_q.push_back(r);
        end
        @(posedge clk);
        #1;
        set_req(0, 1'b1, 1'b0, 5'd3, 5'd7, 16'h1111);
        set_req(1, 1'b1, 1'b1, 5'd4, 5'd8, 16'h2222);
        for (int k = 0; k < n; k++) begin
            wait_start(20);
            repeat (2) @(posedge clk);
            #1;
            m_done = 1'b1;
            m_rdata = 16'hC000 + 16'(k);
            @(posedge clk);
            #1;
            m_done = 1'b0;
            m_rdata = 16'h0;
        end
        @(posedge clk);
        #1;
        r0_req = 1'b0;
        r1_req = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rsp"}, {r0_gnt, r0_done, r0_err, r0_rdata, r1_gnt, r1_done, r1_err, r1_rdata}, 0);
        check({tag, "_m"}, {m_start, m_rw, m_phy, m_reg, m_wdata}, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        set_req(0, 1'b0, 1'b0, 5'd0, 5'd0, 16'h0);
        set_req(1, 1'b0, 1'b0, 5'd0, 5'd0, 16'h0);
        m_done = 1'b0;
        m_rdata = 16'h0;
        mdl_rd[0] = 16'h0;
        mdl_rd[1] = 16'h0;
        #1;
        check_all_zero("reset_state");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        run_txn(0, 1'b0, 5'd1, 5'd4, 16'hABCD, 5, 16'h0);
        run_txn(1, 1'b1, 5'd0, 5'd2, 16'h0, 3, 16'hFEED);
        check("r0_rdata_after_r1", r0_rdata, mdl_rd[0]);
        run_tie(4);
        run_txn(0, 1'b1, 5'd6, 5'd1, 16'h0, -1, 16'h0);
        run_txn(1, 1'b1, 5'd7, 5'd3, 16'h0, 0, 16'h9999);
        run_txn(0, 1'b1, 5'd2, 5'd5, 16'h0, TO, 16'h1234);
        run_txn(1, 1'b0, 5'd8, 5'd6, 16'h5A5A, TO + 1, 16'h7777);
        run_txn(1, 1'b0, 5'd2, 5'd3, 16'h0F0F, 3, 16'h0);

        @(posedge clk);
        #1;
        m_done = 1'b1;
        m_rdata = 16'h5555;
        @(posedge clk);
        #1;
        m_done = 1'b0;
        m_rdata = 16'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stray_idle", {r0_done, r1_done, m_start, r0_gnt, r1_gnt}, 0);
        end
        check("stray_rdata", {r0_rdata, r1_rdata}, {mdl_rd[0], mdl_rd[1]});

        begin
            cmd_t c;
            c.id = 1'b0; c.rw = 1'b1; c.phy = 5'd5; c.rg = 5'd9; c.wd = 16'h0;
            exp_cmd_q.push_back(c);
        end
        @(posedge clk);
        #1;
        set_req(0, 1'b1, 1'b1, 5'd5, 5'd9, 16'h0);
        wait_start(10);
        repeat (4) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check_all_zero("mid_reset");
        set_req(0, 1'b0, 1'b0, 5'd0, 5'd0, 16'h0);
        mdl_rd[0] = 16'h0;
        mdl_rd[1] = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no_done_after_reset", {r0_done, r1_done, m_start}, 0);
        end
        run_tie(2);

        repeat (3) @(negedge clk);
        check("cmd_q_empty", exp_cmd_q.size(), 0);
        check("rsp_q_empty", exp_rsp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
